seg_scan_driver: RTL and testbench

Multiplexed seven-segment scan driver sitting directly downstream of the bottling controller. It consumes the per-digit 4-bit display codes, where 4'hF means blank, plus decimal-point requests. It time-multiplexes these codes onto one shared segment bus with one-hot digit selects. Codes are snapshotted once per frame, so a display never shows a torn mix of old and new values.

---
 rtl/seg_scan_driver_pkg.sv | 29 ++
 rtl/seg_scan_driver_seg7_decode.sv | 30 +++
 rtl/seg_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns,
// the blank code and the scan state encoding.
package seg_scan_driver_pkg;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_R     = 7'h50;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Display code that always renders as an unlit digit
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic [0:0] {
      ST_GUARD = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg_scan_driver_seg7_decode.sv
// Combinational 4-bit display code to active-high seven-segment pattern.
module seg7_decode
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] i_code,
   output logic [6:0] o_seg
);

   // Map each code to its segment pattern; D, E and F render blank
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         4'h0:    o_seg = SEG_0;
         4'h1:    o_seg = SEG_1;
         4'h2:    o_seg = SEG_2;
         4'h3:    o_seg = SEG_3;
         4'h4:    o_seg = SEG_4;
         4'h5:    o_seg = SEG_5;
         4'h6:    o_seg = SEG_6;
         4'h7:    o_seg = SEG_7;
         4'h8:    o_seg = SEG_8;
         4'h9:    o_seg = SEG_9;
         4'hA:    o_seg = SEG_DASH;
         4'hB:    o_seg = SEG_E;
         4'hC:    o_seg = SEG_R;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver. Codes are snapshotted once per
// frame (on entry to digit 0) so a frame never mixes old and new values.
// Outputs are registered from the state being entered, so the cycle a
// digit is selected is exactly the cycle its segments are shown.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int DWELL_CYCLES   = 2,
   parameter int GUARD_CYCLES   = 1,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b1
)(
   input  logic                    clk_1khz,
   input  logic                    switch_clr,
   input  logic [4*NUM_DIGITS-1:0] digit_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_suppress,
   output logic [6:0]              seg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   dig_sel_out,
   output logic                    frame_start
);

   localparam int CNT_MAX0 = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
   localparam int CW       = $clog2(CNT_MAX);
   localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? CW'(GUARD_CYCLES - 1) : CW'(0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   // Polarity is applied only when loading the output registers
   localparam logic [6:0]            SEG_XOR = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_XOR  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] DIG_XOR = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   scan_state_t             r_state;
   logic                    r_run;
   logic [IW-1:0]           r_idx;
   logic [CW-1:0]           r_cnt;
   logic [4*NUM_DIGITS-1:0] r_snap_code;
   logic [NUM_DIGITS-1:0]   r_snap_dp;
   logic                    r_snap_lz;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_dig;
   logic                    r_frame;

   logic                    w_guard_done;
   logic                    w_dwell_done;
   logic                    w_drive_next;
   logic                    w_capture;
   logic [IW-1:0]           w_idx_adv;
   logic [IW-1:0]           w_drive_idx;
   logic [4*NUM_DIGITS-1:0] w_src_flat;
   logic [NUM_DIGITS-1:0]   w_src_dp;
   logic                    w_src_lz;
   logic [3:0]              w_src_code [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   w_blank;
   logic                    w_lead;
   logic [3:0]              w_dec_code;
   logic [6:0]              w_seg;
   logic                    w_dp;
   logic [NUM_DIGITS-1:0]   w_onehot;

   // Look ahead to the digit being driven after this edge and its snapshot source
   always_comb begin
      w_dwell_done = (r_state == ST_DRIVE) && (r_cnt == DWELL_LAST);
      if (r_state == ST_GUARD) begin
         // The first clock after reset starts the guard rather than ending it
         w_guard_done = r_run ? (r_cnt == GUARD_LAST) : (GUARD_CYCLES == 0);
      end else begin
         w_guard_done = 1'b0;
      end
      w_idx_adv    = (r_idx == IDX_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
      w_drive_idx  = w_dwell_done ? w_idx_adv : r_idx;
      w_drive_next = w_guard_done ||
                     ((r_state == ST_DRIVE) && !(w_dwell_done && (GUARD_CYCLES > 0)));
      // Capture only on the edge that newly enters a drive of digit 0
      w_capture    = (w_guard_done || (w_dwell_done && (GUARD_CYCLES == 0))) &&
                     (w_drive_idx == {IW{1'b0}});
      if (w_capture) begin
         w_src_flat = digit_in;
         w_src_dp   = dp_in;
         w_src_lz   = lz_suppress;
      end else begin
         w_src_flat = r_snap_code;
         w_src_dp   = r_snap_dp;
         w_src_lz   = r_snap_lz;
      end
   end

   // Leading-zero blanking: walk from the most significant digit downward
   always_comb begin
      w_lead  = 1'b1;
      w_blank = {NUM_DIGITS{1'b0}};
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         w_src_code[k] = w_src_flat[4*k +: 4];
         w_blank[k]    = w_src_lz && w_lead && (w_src_code[k] == 4'h0) && (k != 0);
         w_lead        = w_lead && ((w_src_code[k] == 4'h0) || (w_src_code[k] == CODE_BLANK));
      end
   end

   // Select the digit to show next; a suppressed digit still keeps its dp
   always_comb begin
      if (w_blank[w_drive_idx]) begin
         w_dec_code = CODE_BLANK;
      end else begin
         w_dec_code = w_src_code[w_drive_idx];
      end
      w_dp     = w_src_dp[w_drive_idx];
      w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_drive_idx;
   end

   seg7_decode u_decode (
      .i_code (w_dec_code),
      .o_seg  (w_seg)
   );

   // Scan FSM, per-frame snapshot and registered, polarity-adjusted outputs
   always_ff @(posedge clk_1khz) begin
      if (switch_clr) begin
         r_state     <= ST_GUARD;
         r_run       <= 1'b0;
         r_idx       <= {IW{1'b0}};
         r_cnt       <= {CW{1'b0}};
         r_snap_code <= {NUM_DIGITS{CODE_BLANK}};
         r_snap_dp   <= {NUM_DIGITS{1'b0}};
         r_snap_lz   <= 1'b0;
         r_seg       <= SEG_BLANK ^ SEG_XOR;
         r_dp        <= DP_XOR;
         r_dig       <= DIG_XOR;
         r_frame     <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (w_capture) begin
            r_snap_code <= digit_in;
            r_snap_dp   <= dp_in;
            r_snap_lz   <= lz_suppress;
         end
         case (r_state)
            ST_GUARD: begin
               if (w_guard_done) begin
                  r_state <= ST_DRIVE;
                  r_cnt   <= {CW{1'b0}};
               end else if (r_run) begin
                  r_cnt <= r_cnt + CW'(1);
               end else begin
                  r_cnt <= {CW{1'b0}};
               end
            end
            ST_DRIVE: begin
               if (w_dwell_done) begin
                  r_idx   <= w_idx_adv;
                  r_cnt   <= {CW{1'b0}};
                  r_state <= (GUARD_CYCLES > 0) ? ST_GUARD : ST_DRIVE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_GUARD;
               r_cnt   <= {CW{1'b0}};
            end
         endcase
         if (w_drive_next) begin
            r_seg   <= w_seg ^ SEG_XOR;
            r_dp    <= w_dp ^ DP_XOR;
            r_dig   <= w_onehot ^ DIG_XOR;
            r_frame <= w_capture;
         end else begin
            r_seg   <= SEG_BLANK ^ SEG_XOR;
            r_dp    <= DP_XOR;
            r_dig   <= DIG_XOR;
            r_frame <= 1'b0;
         end
      end
   end

   assign seg_out     = r_seg;
   assign dp_out      = r_dp;
   assign dig_sel_out = r_dig;
   assign frame_start = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with default parameters
// (6 digits, dwell 2, guard 1, active-high segments, active-low selects).
module tb_seg_scan_driver;

   typedef struct packed {
      logic [5:0] dig;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } exp_t;

   logic        clk_1khz;
   logic        switch_clr;
   logic [23:0] digit_in;
   logic [5:0]  dp_in;
   logic        lz_suppress;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [5:0]  dig_sel_out;
   logic        frame_start;

   exp_t sb_q[$];
   int   n_cmp;
   int   n_bad;
   logic mon_en;
   logic end_chk;
   logic end_done;
   logic prev_active;
   logic [5:0] prev_dig;

   seg_scan_driver dut (
      .clk_1khz    (clk_1khz),
      .switch_clr  (switch_clr),
      .digit_in    (digit_in),
      .dp_in       (dp_in),
      .lz_suppress (lz_suppress),
      .seg_out     (seg_out),
      .dp_out      (dp_out),
      .dig_sel_out (dig_sel_out),
      .frame_start (frame_start)
   );

   initial clk_1khz = 1'b0;
   always #5 clk_1khz = ~clk_1khz;

   // Push the first n drive cycles of a frame: digit k twice, digit 0 first
   task automatic push_frame(input logic [41:0] segs, input logic [5:0] dps, input int n);
      exp_t e;
      logic [5:0] one;
      int cnt;
      one = 6'b000001;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 2; c++) begin
            e.dig = ~(one << k);
            e.seg = segs[7*k +: 7];
            e.dp  = dps[k];
            e.fs  = (k == 0) && (c == 0);
            if (cnt < n) sb_q.push_back(e);
            cnt++;
         end
      end
   endtask

   // Called one negedge before a snapshot edge: apply inputs, expect a full frame
   task automatic frame(input logic [23:0] d, input logic [5:0] dp, input logic lz,
                        input logic [41:0] segs, input logic [5:0] dps);
      digit_in    = d;
      dp_in       = dp;
      lz_suppress = lz;
      push_frame(segs, dps, 12);
      repeat (18) @(negedge clk_1khz);
   endtask

   // Monitor: every cycle is either an idle cycle or a drive cycle matched to the queue
   always @(negedge clk_1khz) begin
      if (mon_en) begin
         if (dig_sel_out != 6'b111111) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_drive: got dig=%b seg=%h dp=%b fs=%b, required no drive",
                        dig_sel_out, seg_out, dp_out, frame_start);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               n_cmp++;
               if ({dig_sel_out, seg_out, dp_out, frame_start} !== e) begin
                  n_bad++;
                  $display("FAIL drive_cycle @%0t: got dig=%b seg=%h dp=%b fs=%b, required dig=%b seg=%h dp=%b fs=%b",
                           $time, dig_sel_out, seg_out, dp_out, frame_start, e.dig, e.seg, e.dp, e.fs);
               end
            end
            if (prev_active && (prev_dig != dig_sel_out)) begin
               n_cmp++;
               n_bad++;
               $display("FAIL guard_gap @%0t: got dig=%b right after dig=%b, required an idle cycle between",
                        $time, dig_sel_out, prev_dig);
            end
         end else begin
            n_cmp++;
            if ({seg_out, dp_out, frame_start} !== 9'h000) begin
               n_bad++;
               $display("FAIL idle_cycle @%0t: got seg=%h dp=%b fs=%b, required seg=00 dp=0 fs=0",
                        $time, seg_out, dp_out, frame_start);
            end
         end
         prev_active = (dig_sel_out != 6'b111111);
         prev_dig    = dig_sel_out;
         if (end_chk && !end_done) begin
            end_done = 1'b1;
            n_cmp++;
            if (sb_q.size() != 0) begin
               n_bad++;
               $display("FAIL leftover_expect: got %0d expected drive cycles never seen, required 0",
                        sb_q.size());
            end
         end
      end
   end

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      mon_en      = 1'b0;
      end_chk     = 1'b0;
      end_done    = 1'b0;
      prev_active = 1'b0;
      prev_dig    = 6'b111111;
      switch_clr  = 1'b1;
      digit_in    = 24'h543210;
      dp_in       = 6'b000000;
      lz_suppress = 1'b0;

      // Reset held for 5 cycles; monitor sees only idle cycles
      @(posedge clk_1khz);
      mon_en = 1'b1;
      repeat (5) @(negedge clk_1khz);
      switch_clr = 1'b0;
      @(negedge clk_1khz);

      // Scan order: digits 5..0 = 5,4,3,2,1,0
      frame(24'h543210, 6'b000000, 1'b0,
            {7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F}, 6'b000000);

      // Snapshot integrity: digit 3 changes 2 -> 8 while digit 1 is driven
      digit_in = 24'h542210;
      push_frame({7'h6D, 7'h66, 7'h5B, 7'h5B, 7'h06, 7'h3F}, 6'b000000, 12);
      repeat (4) @(negedge clk_1khz);
      digit_in = 24'h548210;
      repeat (14) @(negedge clk_1khz);
      frame(24'h548210, 6'b000000, 1'b0,
            {7'h6D, 7'h66, 7'h7F, 7'h5B, 7'h06, 7'h3F}, 6'b000000);

      // Leading-zero suppression on 0,0,F,0,7,0; dp survives on a suppressed digit
      frame(24'h00F070, 6'b100000, 1'b1,
            {7'h00, 7'h00, 7'h00, 7'h00, 7'h07, 7'h3F}, 6'b100000);
      frame(24'h00F070, 6'b000000, 1'b0,
            {7'h3F, 7'h3F, 7'h00, 7'h3F, 7'h07, 7'h3F}, 6'b000000);

      // Decimal point and specials: A on digit 2, B on digit 3
      frame(24'h00BA98, 6'b000100, 1'b0,
            {7'h3F, 7'h3F, 7'h79, 7'h40, 7'h6F, 7'h7F}, 6'b000100);

      // C renders 'r'; D/E are blank but not zero, so no leading-zero blanking
      frame(24'hEDC000, 6'b000000, 1'b1,
            {7'h00, 7'h00, 7'h50, 7'h3F, 7'h3F, 7'h3F}, 6'b000000);

      // Mid-frame reset during digit 4's first dwell cycle
      digit_in    = 24'h123456;
      dp_in       = 6'b000000;
      lz_suppress = 1'b0;
      push_frame({7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}, 6'b000000, 9);
      repeat (13) @(negedge clk_1khz);
      switch_clr = 1'b1;
      repeat (3) @(negedge clk_1khz);
      digit_in   = 24'h987654;
      switch_clr = 1'b0;
      @(negedge clk_1khz);
      frame(24'h987654, 6'b000000, 1'b0,
            {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66}, 6'b000000);

      // Stop scanning and confirm every expected drive cycle was seen
      switch_clr = 1'b1;
      end_chk    = 1'b1;
      repeat (3) @(negedge clk_1khz);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
